// File: rtl/mac_pkg.sv
// Shared types and the accumulator scaling helper for the MAC array.
package mac_pkg;

  // Widest accumulator the scaling helper supports.
  localparam int unsigned MaxW = 128;

  typedef struct packed {
    logic round;
    logic sat;
  } mac_mode_t;

  typedef struct packed {
    logic            ovf;
    logic [MaxW-1:0] val;
  } mac_scaled_t;

  // Optionally round half-up, arithmetic shift by scale, then range-check
  // against a signed out_w-bit result and clamp when sat is set.
  // Without sat the caller keeps the low out_w bits of val.
  function automatic mac_scaled_t mac_scale(input logic signed [MaxW-1:0] s,
                                            input logic                   round,
                                            input logic                   sat,
                                            input int unsigned            scale,
                                            input int unsigned            out_w);
    logic signed [MaxW-1:0] t;
    logic signed [MaxW-1:0] r;
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    mac_scaled_t            res;
    t = s;
    if (round && (scale != 0)) begin
      t = t + (MaxW'(1) << (scale - 1));
    end
    r  = t >>> scale;
    hi = (MaxW'(1) << (out_w - 1)) - MaxW'(1);
    lo = ~hi;
    res.ovf = (r > hi) || (r < lo);
    if (sat && (r > hi)) begin
      res.val = hi;
    end else if (sat && (r < lo)) begin
      res.val = lo;
    end else begin
      res.val = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: operand register, product pipeline, accumulator and result
// register. Pipeline enable and transaction control come from mac_array.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned OUT_SCALE = 16,
  parameter int unsigned PIPE      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic signed [A_WIDTH-1:0]   a_i,
  input  logic signed [B_WIDTH-1:0]   b_i,
  input  logic                        acc_en_i,
  input  logic                        last_i,
  input  mac_mode_t                   mode_i,
  output logic        [OUT_WIDTH-1:0] res_o,
  output logic                        ovf_o
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0]   a_q;
  logic signed [B_WIDTH-1:0]   b_q;
  logic signed [PW-1:0]        prod_d [PIPE];
  logic signed [PW-1:0]        prod_q [PIPE];
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] sum;
  logic        [OUT_WIDTH-1:0] res_d, res_q;
  logic                        ovf_d, ovf_q;
  mac_scaled_t                 scaled;
  logic                        unused_hi;

  // Full-precision product enters stage 0, then shifts down the pipe.
  always_comb begin
    prod_d[0] = PW'(a_q) * PW'(b_q);
    for (int i = 1; i < PIPE; i++) begin
      prod_d[i] = prod_q[i-1];
    end
  end

  // Accumulate non-last beats; on the last beat scale into the result and
  // restart the accumulator from zero.
  always_comb begin
    sum    = acc_q + ACC_WIDTH'(prod_q[PIPE-1]);
    scaled = mac_scale(MaxW'(sum), mode_i.round, mode_i.sat, OUT_SCALE, OUT_WIDTH);
    acc_d  = acc_q;
    res_d  = res_q;
    ovf_d  = ovf_q;
    if (acc_en_i) begin
      if (last_i) begin
        acc_d = '0;
        res_d = scaled.val[OUT_WIDTH-1:0];
        ovf_d = scaled.ovf;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Only the low OUT_WIDTH bits of the scaled value reach the result.
  assign unused_hi = ^scaled.val[MaxW-1:OUT_WIDTH];

  // Operand and product registers advance together under the shared enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        prod_q[i] <= '0;
      end
    end else if (en_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      prod_q <= prod_d;
    end
  end

  // Accumulator and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign res_o = res_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_array.sv
// Multi-lane pipelined signed MAC with valid/ready handshake. Owns the
// handshake, per-stage valid/last/mode tracking and the output valid flag.
module mac_array
  import mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned OUT_SCALE = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned PIPE      = 2
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*A_WIDTH-1:0]   a_in,
  input  logic [LANES*B_WIDTH-1:0]   b_in,
  input  logic                       in_last,
  input  logic                       round_in,
  input  logic                       sat_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_WIDTH-1:0] out,
  output logic [LANES-1:0]           out_ovf
);

  logic                  stall, en, fire, res_load;
  logic                  v0_d, v0_q;
  logic                  last0_d, last0_q;
  mac_mode_t             mode0_d, mode0_q;
  logic      [PIPE-1:0]  vld_d, vld_q;
  logic      [PIPE-1:0]  last_d, last_q;
  mac_mode_t [PIPE-1:0]  mode_d, mode_q;
  logic                  out_valid_d, out_valid_q;

  // Handshake: a held result that is not being taken freezes everything.
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    en       = ~stall;
    in_ready = en;
    fire     = vld_q[PIPE-1] & en;
    res_load = fire & last_q[PIPE-1];
  end

  // Control shadow of the datapath: operand stage then PIPE product stages.
  always_comb begin
    v0_d         = in_valid;
    last0_d      = in_last;
    mode0_d.round = round_in;
    mode0_d.sat   = sat_in;
    vld_d[0]     = v0_q;
    last_d[0]    = last0_q;
    mode_d[0]    = mode0_q;
    for (int i = 1; i < PIPE; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
      mode_d[i] = mode_q[i-1];
    end
    // A new result may replace a consumed one in the same edge.
    if (res_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Stage valids advance only when not stalled.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      v0_q        <= 1'b0;
      last0_q     <= 1'b0;
      mode0_q     <= '0;
      vld_q       <= '0;
      last_q      <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (en) begin
        v0_q    <= v0_d;
        last0_q <= last0_d;
        mode0_q <= mode0_d;
        vld_q   <= vld_d;
        last_q  <= last_d;
        mode_q  <= mode_d;
      end
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mac_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .OUT_SCALE(OUT_SCALE),
      .PIPE     (PIPE)
    ) u_lane (
      .clk_i   (clk),
      .rst_ni  (arst_n_in),
      .en_i    (en),
      .a_i     (a_in[gi*A_WIDTH +: A_WIDTH]),
      .b_i     (b_in[gi*B_WIDTH +: B_WIDTH]),
      .acc_en_i(fire),
      .last_i  (last_q[PIPE-1]),
      .mode_i  (mode_q[PIPE-1]),
      .res_o   (out[gi*OUT_WIDTH +: OUT_WIDTH]),
      .ovf_o   (out_ovf[gi])
    );
  end

endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench for mac_array: the driver pushes model results when a
// last beat is accepted, the monitor pops on every output handshake.
module tb_mac_array;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned SC = 16;
  localparam int unsigned LN = 4;
  localparam int unsigned PP = 2;

  typedef struct packed {
    logic [LN*OW-1:0] res;
    logic [LN-1:0]    ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst_n_in;
  logic             in_valid, in_ready, in_last, round_in, sat_in;
  logic [LN*AW-1:0] a_in;
  logic [LN*BW-1:0] b_in;
  logic             out_valid, out_ready;
  logic [LN*OW-1:0] out;
  logic [LN-1:0]    out_ovf;

  int     total = 0;
  int     bad = 0;
  exp_t   exp_q[$];
  longint acc_m[LN];
  bit     rand_ready = 1'b0;

  mac_array #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(48), .OUT_WIDTH(OW),
    .OUT_SCALE(SC), .LANES(LN), .PIPE(PP)
  ) dut (
    .clk      (clk),
    .arst_n_in(arst_n_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_last  (in_last),
    .round_in (round_in),
    .sat_in   (sat_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, half-up rounding, floor shift, range clamp.
  function automatic void model_res(input longint s, input bit rnd, input bit sat,
                                    output logic [OW-1:0] o, output logic ovf);
    longint r;
    longint t;
    if (rnd) s = s + 32768;
    r   = s >>> SC;
    ovf = (r > 32767) || (r < -32768);
    if (sat && r > 32767) r = 32767;
    if (sat && r < -32768) r = -32768;
    t = r;
    o = t[OW-1:0];
  endfunction

  task automatic send_beat(input logic [LN*AW-1:0] av, input logic [LN*BW-1:0] bv,
                           input bit last, input bit rnd, input bit sat);
    bit   got = 1'b0;
    exp_t e;
    logic [OW-1:0] o;
    logic ov;
    a_in = av; b_in = bv; in_last = last; round_in = rnd; sat_in = sat; in_valid = 1'b1;
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
    end else begin
      for (int l = 0; l < LN; l++) begin
        acc_m[l] += longint'($signed(av[l*AW +: AW])) * longint'($signed(bv[l*BW +: BW]));
      end
      if (last) begin
        for (int l = 0; l < LN; l++) begin
          model_res(acc_m[l], rnd, sat, o, ov);
          e.res[l*OW +: OW] = o;
          e.ovf[l] = ov;
          acc_m[l] = 0;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
    end
  endtask

  function automatic logic [LN*AW-1:0] rep(input logic [AW-1:0] v);
    return {LN{v}};
  endfunction

  // Monitor: a result is consumed at the next edge when valid & ready.
  always @(negedge clk) begin
    if (arst_n_in) begin
      chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %h expected none", out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", 64'(out), 64'(e.res));
          chk("ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arst_n_in = 1'b0; in_valid = 1'b0; in_last = 1'b0; round_in = 1'b0; sat_in = 1'b0;
    a_in = '0; b_in = '0; out_ready = 1'b1;
    for (int l = 0; l < LN; l++) acc_m[l] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    arst_n_in = 1'b1;
    @(posedge clk); #1;

    // Single beat with latency measurement.
    send_beat(rep(16'd256), rep(16'd256), 1, 0, 0);
    n = 0;
    for (int t = 1; t <= 20 && n == 0; t++) begin
      @(posedge clk); #1;
      if (out_valid) n = t;
    end
    chk("latency", 64'(n), 64'(PP + 1));
    drain();

    // Rounding.
    send_beat(rep(16'd1), rep(16'h8000), 1, 0, 0);
    send_beat(rep(16'd1), rep(16'h8000), 1, 1, 0);
    // Accumulation and overflow handling.
    for (int i = 0; i < 4; i++) send_beat(rep(16'h4000), rep(16'h4000), i == 3, 0, 0);
    for (int i = 0; i < 8; i++) send_beat(rep(16'h7fff), rep(16'h7fff), i == 7, 0, 1);
    for (int i = 0; i < 8; i++) send_beat(rep(16'h7fff), rep(16'h7fff), i == 7, 0, 0);
    drain();

    // Backpressure: two results held behind a blocked output.
    out_ready = 1'b0;
    send_beat(rep(16'd256), rep(16'd256), 1, 0, 0);
    send_beat(rep(16'd512), rep(16'd256), 1, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_held_out", 64'(out[OW-1:0]), 64'd1);
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Lane independence.
    send_beat({16'd1024, 16'd768, 16'd512, 16'd256}, rep(16'd256), 1, 0, 0);
    drain();

    // Randomised transactions with gaps and random backpressure.
    rand_ready = 1'b1;
    for (int tr = 0; tr < 40; tr++) begin
      int  nb;
      bit  rnd, sat;
      nb  = $urandom_range(1, 8);
      rnd = $urandom_range(0, 1);
      sat = $urandom_range(0, 1);
      for (int b = 0; b < nb; b++) begin
        logic [LN*AW-1:0] av;
        logic [LN*BW-1:0] bv;
        for (int l = 0; l < LN; l++) begin
          av[l*AW +: AW] = AW'($urandom);
          bv[l*BW +: BW] = BW'($urandom);
        end
        send_beat(av, bv, b == nb - 1, rnd, sat);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset in the middle of a transaction discards the partial sum.
    send_beat(rep(16'h4000), rep(16'h4000), 0, 0, 0);
    send_beat(rep(16'h4000), rep(16'h4000), 0, 0, 0);
    #2;
    arst_n_in = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out", 64'(out), 64'd0);
    chk("mid_rst_ovf", 64'(out_ovf), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int l = 0; l < LN; l++) acc_m[l] = 0;
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    send_beat(rep(16'd256), rep(16'd256), 1, 0, 0);
    drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
